// File: rtl/digit_frame_scheduler_pkg.sv
// Shared types for the digit frame scheduler: FSM states, frame phase codes and count helpers.
// Phase codes are also consumed by the recognition datapath.
package digit_frame_scheduler_pkg;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned PHASE_W = 2;
    localparam int unsigned ERR_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PROJ = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    typedef enum logic [PHASE_W-1:0] {
        FRM_PROJ    = 2'd0,
        FRM_SETTLE  = 2'd1,
        FRM_FEATURE = 2'd2,
        FRM_RESULT  = 2'd3
    } phase_e;

    // Digit grid geometry reported by the projection block.
    typedef struct packed {
        logic [CNT_W-1:0] row;
        logic [CNT_W-1:0] col;
    } counts_t;

    // A projection is usable only if it found at least one digit and fits the recognition grid.
    function automatic logic counts_ok(input counts_t c,
                                       input logic [CNT_W-1:0] row_max,
                                       input logic [CNT_W-1:0] col_max);
        return (c.row != '0) && (c.row <= row_max) &&
               (c.col != '0) && (c.col <= col_max);
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
    endfunction

endpackage

// File: rtl/digit_frame_scheduler_vsync_edge_det.sv
// Registered rising-edge detector for camera vsync; ignores a vsync that is already high
// when reset is released until it has been seen low once.
module vsync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync_i,
    output logic rise_o
);

    logic vsync_d1_q;
    logic armed_q;
    logic rise_q;
    logic rise_d;

    assign rise_d = vsync_i & ~vsync_d1_q & armed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d1_q <= 1'b0;
            armed_q    <= 1'b0;
            rise_q     <= 1'b0;
        end else begin
            vsync_d1_q <= vsync_i;
            armed_q    <= armed_q | ~vsync_i;
            rise_q     <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/digit_frame_scheduler.sv
// Frame-level sequencer for the digit recognition pipeline: projection, border settle,
// feature extract and result phases, one video frame each, with a frame watchdog.
module digit_frame_scheduler
    import digit_frame_scheduler_pkg::*;
#(
    parameter int unsigned NUM_ROW_MAX = 1,
    parameter int unsigned NUM_COL_MAX = 4,
    parameter int unsigned WDOG_W      = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               frame_vsync,
    input  logic [CNT_W-1:0]   row_num_in,
    input  logic [CNT_W-1:0]   col_num_in,
    output logic [PHASE_W-1:0] frame_cnt,
    output logic               project_done_flag,
    output logic [CNT_W-1:0]   num_row,
    output logic [CNT_W-1:0]   num_col,
    output logic               proj_clr,
    output logic               digit_valid,
    output logic [ERR_W-1:0]   err_cnt,
    output logic               timeout
);

    localparam logic [CNT_W-1:0]  ROW_MAX   = CNT_W'(NUM_ROW_MAX);
    localparam logic [CNT_W-1:0]  COL_MAX   = CNT_W'(NUM_COL_MAX);
    localparam logic [WDOG_W-1:0] WDOG_LAST = {WDOG_W{1'b1}};

    state_e              state_q;
    phase_e              phase_q;
    logic                flag_q;
    counts_t             counts_q;
    logic                proj_clr_q;
    logic                digit_valid_q;
    logic [ERR_W-1:0]    err_q;
    logic                timeout_q;
    logic [WDOG_W-1:0]   wdog_q;

    logic                frame_start;
    counts_t             counts_in;
    logic                counts_in_ok;
    logic                wdog_expire_c;

    vsync_edge_det u_vsync_edge_det (
        .clk     (clk),
        .rst_n   (rst_n),
        .vsync_i (frame_vsync),
        .rise_o  (frame_start)
    );

    assign counts_in     = '{row: row_num_in, col: col_num_in};
    assign counts_in_ok  = counts_ok(counts_in, ROW_MAX, COL_MAX);
    // A frame_start on the expiry cycle takes priority over the timeout.
    assign wdog_expire_c = (state_q != ST_IDLE) && !frame_start && (wdog_q == WDOG_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            phase_q       <= FRM_PROJ;
            flag_q        <= 1'b0;
            counts_q      <= '0;
            proj_clr_q    <= 1'b0;
            digit_valid_q <= 1'b0;
            err_q         <= '0;
            timeout_q     <= 1'b0;
            wdog_q        <= '0;
        end else begin
            proj_clr_q    <= 1'b0;
            digit_valid_q <= 1'b0;

            if (wdog_expire_c) begin
                state_q   <= ST_IDLE;
                phase_q   <= FRM_PROJ;
                flag_q    <= 1'b0;
                timeout_q <= 1'b1;
                wdog_q    <= '0;
            end else begin
                wdog_q <= (state_q == ST_IDLE || frame_start) ? '0 : wdog_q + WDOG_W'(1);

                if (frame_start) begin
                    unique case (state_q)
                        ST_IDLE: begin
                            if (enable) begin
                                state_q    <= ST_PROJ;
                                proj_clr_q <= 1'b1;
                                timeout_q  <= 1'b0;
                            end
                        end
                        ST_PROJ: begin
                            if (!enable) begin
                                state_q <= ST_IDLE;
                            end else if (counts_in_ok) begin
                                counts_q <= counts_in;
                                flag_q   <= 1'b1;
                                phase_q  <= FRM_SETTLE;
                                state_q  <= ST_RUN;
                            end else begin
                                err_q      <= sat_inc(err_q);
                                proj_clr_q <= 1'b1;
                            end
                        end
                        ST_RUN: begin
                            if (phase_q == FRM_RESULT) begin
                                flag_q     <= 1'b0;
                                phase_q    <= FRM_PROJ;
                                proj_clr_q <= 1'b1;
                                state_q    <= enable ? ST_PROJ : ST_IDLE;
                            end else if (!enable) begin
                                flag_q  <= 1'b0;
                                phase_q <= FRM_PROJ;
                                state_q <= ST_IDLE;
                            end else begin
                                phase_q <= (phase_q == FRM_SETTLE) ? FRM_FEATURE : FRM_RESULT;
                                if (phase_q == FRM_FEATURE) begin
                                    digit_valid_q <= 1'b1;
                                end
                            end
                        end
                        default: begin
                            state_q <= ST_IDLE;
                            flag_q  <= 1'b0;
                            phase_q <= FRM_PROJ;
                        end
                    endcase
                end
            end
        end
    end

    assign frame_cnt         = phase_q;
    assign project_done_flag = flag_q;
    assign num_row           = counts_q.row;
    assign num_col           = counts_q.col;
    assign proj_clr          = proj_clr_q;
    assign digit_valid       = digit_valid_q;
    assign err_cnt           = err_q;
    assign timeout           = timeout_q;

endmodule

// File: tb/tb_digit_frame_scheduler.sv
// Scoreboard bench for digit_frame_scheduler: stimulus queues the expected output snapshot of
// every frame that should change the outputs; a negedge monitor pops it when the DUT shows one.
module tb_digit_frame_scheduler;

    localparam int unsigned WDOG_W = 6;

    typedef struct packed {
        logic [1:0] fc;
        logic       flag;
        logic [3:0] nr;
        logic [3:0] nc;
        logic       pc;
        logic       dv;
        logic [7:0] err;
        logic       to;
    } snap_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       frame_vsync;
    logic [3:0] row_num_in;
    logic [3:0] col_num_in;
    logic [1:0] frame_cnt;
    logic       project_done_flag;
    logic [3:0] num_row;
    logic [3:0] num_col;
    logic       proj_clr;
    logic       digit_valid;
    logic [7:0] err_cnt;
    logic       timeout;

    int    n_cmp = 0;
    int    n_bad = 0;
    snap_t exp_q[$];
    bit    mon_en = 1'b0;
    snap_t prev_s = '0;
    snap_t cur_s;
    snap_t exp_s;

    digit_frame_scheduler #(
        .NUM_ROW_MAX (1),
        .NUM_COL_MAX (4),
        .WDOG_W      (WDOG_W)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .enable            (enable),
        .frame_vsync       (frame_vsync),
        .row_num_in        (row_num_in),
        .col_num_in        (col_num_in),
        .frame_cnt         (frame_cnt),
        .project_done_flag (project_done_flag),
        .num_row           (num_row),
        .num_col           (num_col),
        .proj_clr          (proj_clr),
        .digit_valid       (digit_valid),
        .err_cnt           (err_cnt),
        .timeout           (timeout)
    );

    always #5 clk = ~clk;

    function automatic snap_t sample();
        return '{fc: frame_cnt, flag: project_done_flag, nr: num_row, nc: num_col,
                 pc: proj_clr, dv: digit_valid, err: err_cnt, to: timeout};
    endfunction

    function automatic snap_t levels(input snap_t s);
        snap_t r = s;
        r.pc = 1'b0;
        r.dv = 1'b0;
        return r;
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("fc=%0d flag=%0b row=%0d col=%0d clr=%0b dv=%0b err=%0d to=%0b",
                         s.fc, s.flag, s.nr, s.nc, s.pc, s.dv, s.err, s.to);
    endfunction

    task automatic push(input int fc, input int flag, input int nr, input int nc,
                        input int pc, input int dv, input int err, input int to);
        exp_q.push_back('{fc: 2'(fc), flag: 1'(flag), nr: 4'(nr), nc: 4'(nc),
                          pc: 1'(pc), dv: 1'(dv), err: 8'(err), to: 1'(to)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One vsync pulse of 'hi' cycles; next rising edge 'period' cycles after this one.
    task automatic send_frame(input logic [3:0] r, input logic [3:0] c, input logic en,
                              input int hi, input int period);
        row_num_in  = r;
        col_num_in  = c;
        enable      = en;
        frame_vsync = 1'b1;
        repeat (hi) tick();
        frame_vsync = 1'b0;
        repeat (period - hi) tick();
    endtask

    task automatic check_direct(input string name);
        snap_t s = sample();
        n_cmp++;
        if (s !== snap_t'('0)) begin
            n_bad++;
            $display("FAIL %s: got %s, want all zero", name, fmt(s));
        end
    endtask

    // Monitor: an output event is any pulse or any change of the level outputs.
    always @(negedge clk) begin
        if (mon_en) begin
            cur_s = sample();
            if (cur_s.pc || cur_s.dv || (levels(cur_s) !== levels(prev_s))) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event @%0t: got %s, want no event", $time, fmt(cur_s));
                end else begin
                    exp_s = exp_q.pop_front();
                    if (cur_s !== exp_s) begin
                        n_bad++;
                        $display("FAIL event @%0t: got %s, want %s", $time, fmt(cur_s), fmt(exp_s));
                    end
                end
            end
            prev_s = cur_s;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, %0d events pending", exp_q.size());
        $fatal(1, "bench time limit");
    end

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        frame_vsync = 1'b0;
        row_num_in  = '0;
        col_num_in  = '0;
        repeat (3) tick();
        check_direct("reset_state");
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (3) tick();

        // Full cycle with valid counts
        push(0, 0, 0, 0, 1, 0, 0, 0); send_frame(1, 4, 1, 2, 20);
        push(1, 1, 1, 4, 0, 0, 0, 0); send_frame(1, 4, 1, 2, 20);
        push(2, 1, 1, 4, 0, 0, 0, 0); send_frame(1, 4, 1, 2, 20);
        push(3, 1, 1, 4, 0, 1, 0, 0); send_frame(1, 4, 1, 2, 20);
        push(0, 0, 1, 4, 1, 0, 0, 0); send_frame(1, 4, 1, 2, 20);

        // Rejected projections, then a valid one
        push(0, 0, 1, 4, 1, 0, 1, 0); send_frame(1, 5, 1, 2, 20);
        push(0, 0, 1, 4, 1, 0, 2, 0); send_frame(0, 2, 1, 2, 20);
        push(1, 1, 1, 2, 0, 0, 2, 0); send_frame(1, 2, 1, 2, 20);

        // Abort at phase 2 with enable low; idle frame gives no event
        push(2, 1, 1, 2, 0, 0, 2, 0); send_frame(1, 2, 1, 2, 20);
        push(0, 0, 1, 2, 0, 0, 2, 0); send_frame(1, 2, 0, 2, 20);
        send_frame(1, 2, 0, 2, 20);

        // Watchdog: start on the expiry cycle survives, then vsync stops
        push(0, 0, 1, 2, 1, 0, 2, 0); send_frame(1, 3, 1, 2, 20);
        push(1, 1, 1, 3, 0, 0, 2, 0); send_frame(1, 3, 1, 2, 64);
        push(2, 1, 1, 3, 0, 0, 2, 0);
        push(0, 0, 1, 3, 0, 0, 2, 1); send_frame(1, 3, 1, 2, 90);
        push(0, 0, 1, 3, 1, 0, 2, 0); send_frame(1, 4, 1, 2, 20);

        // Asynchronous reset while in phase 2
        push(1, 1, 1, 4, 0, 0, 2, 0); send_frame(1, 4, 1, 2, 20);
        push(2, 1, 1, 4, 0, 0, 2, 0); send_frame(1, 4, 1, 2, 6);
        #2;
        push(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check_direct("async_reset");
        frame_vsync = 1'b1;
        enable      = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        frame_vsync = 1'b0;
        repeat (5) tick();
        send_frame(1, 4, 0, 2, 20);

        // Long vsync gives one start only
        push(0, 0, 0, 0, 1, 0, 0, 0); send_frame(1, 4, 1, 10, 20);

        // Error counter saturation
        for (int i = 1; i <= 256; i++) begin
            push(0, 0, 0, 0, 1, 0, (i > 255) ? 255 : i, 0);
            send_frame((i % 2 == 1) ? 4'd2 : 4'd0, 4'd1, 1'b1, 2, 8);
        end
        push(1, 1, 1, 1, 0, 0, 255, 0); send_frame(1, 1, 1, 2, 20);

        repeat (10) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_events: got %0d still queued, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
